// File: rtl/tomasulo_pkg.sv
// Types shared by the reservation stations, the CDB buffer and the functional units:
// tag/data widths, opcode encoding, slot state and the packed slot record.
package tomasulo_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  // Tag 0 marks an operand whose value is already present.
  localparam logic [TAG_W-1:0] NO_TAG = '0;

  typedef enum logic [1:0] {
    OP_ADD  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MUL  = 2'd2,
    OP_PASS = 2'd3
  } op_t;

  typedef enum logic [1:0] {
    FREE      = 2'd0,
    WAITING   = 2'd1,
    READY     = 2'd2,
    EXECUTING = 2'd3
  } rs_state_t;

  typedef struct packed {
    rs_state_t          state;
    op_t                op;
    logic [TAG_W-1:0]   src1_tag;
    logic [DATA_W-1:0]  src1_data;
    logic [TAG_W-1:0]   src2_tag;
    logic [DATA_W-1:0]  src2_data;
  } rs_entry_t;

endpackage

// File: rtl/rs_entry.sv
// One reservation-station slot: FREE/WAITING/READY/EXECUTING state machine with
// operand capture from the add and mul broadcast buses (add bus has priority).
module rs_entry
  import tomasulo_pkg::*;
#(
  parameter int TAG_W  = tomasulo_pkg::TAG_W,
  parameter int DATA_W = tomasulo_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TAG_W-1:0]  slot_tag,
  input  logic              alloc,
  input  op_t               issue_op,
  input  logic [TAG_W-1:0]  issue_src1_tag,
  input  logic [DATA_W-1:0] issue_src1_data,
  input  logic [TAG_W-1:0]  issue_src2_tag,
  input  logic [DATA_W-1:0] issue_src2_data,
  input  logic [TAG_W-1:0]  add_tag,
  input  logic [DATA_W-1:0] add_data,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [DATA_W-1:0] mul_data,
  input  logic              grant,
  output logic              is_free,
  output logic              is_ready,
  output op_t               op,
  output logic [DATA_W-1:0] src1_data,
  output logic [DATA_W-1:0] src2_data
);

  localparam logic [TAG_W-1:0] NONE = '0;

  rs_state_t         state_q, state_d;
  op_t               op_q, op_d;
  logic [TAG_W-1:0]  tag1_q, tag1_d, tag2_q, tag2_d;
  logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
  logic              done;

  // An operand waiting on a tag takes the value of whichever bus carries that tag.
  function automatic logic [TAG_W+DATA_W-1:0] snoop(
    input logic [TAG_W-1:0]  tag,
    input logic [DATA_W-1:0] data,
    input logic [TAG_W-1:0]  a_tag,
    input logic [DATA_W-1:0] a_data,
    input logic [TAG_W-1:0]  m_tag,
    input logic [DATA_W-1:0] m_data
  );
    if (tag != NONE && tag == a_tag) return {NONE, a_data};
    if (tag != NONE && tag == m_tag) return {NONE, m_data};
    return {tag, data};
  endfunction

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FREE;
    else       state_q <= state_d;
  end

  // NOTE: the slot payload is reset along with the FSM so a dropped op can never
  // leave stale operands behind for the dispatch mux.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_ADD;
      tag1_q  <= NONE;
      data1_q <= '0;
      tag2_q  <= NONE;
      data2_q <= '0;
    end else begin
      op_q    <= op_d;
      tag1_q  <= tag1_d;
      data1_q <= data1_d;
      tag2_q  <= tag2_d;
      data2_q <= data2_d;
    end
  end

  // Operand capture: issue (with same-cycle bypass) or wakeup while WAITING.
  always_comb begin
    // NOTE: defaults first on every path keep this block free of inferred latches.
    op_d               = op_q;
    {tag1_d, data1_d}  = {tag1_q, data1_q};
    {tag2_d, data2_d}  = {tag2_q, data2_q};
    if (alloc) begin
      op_d              = issue_op;
      {tag1_d, data1_d} = snoop(issue_src1_tag, issue_src1_data, add_tag, add_data, mul_tag, mul_data);
      {tag2_d, data2_d} = snoop(issue_src2_tag, issue_src2_data, add_tag, add_data, mul_tag, mul_data);
    end else if (state_q == WAITING) begin
      {tag1_d, data1_d} = snoop(tag1_q, data1_q, add_tag, add_data, mul_tag, mul_data);
      {tag2_d, data2_d} = snoop(tag2_q, data2_q, add_tag, add_data, mul_tag, mul_data);
    end
  end

  // slot_tag is never NO_TAG, so an idle bus cannot complete a slot.
  assign done = (add_tag == slot_tag) || (mul_tag == slot_tag);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FREE:      if (alloc) state_d = (tag1_d == NONE && tag2_d == NONE) ? READY : WAITING;
      WAITING:   if (tag1_d == NONE && tag2_d == NONE) state_d = READY;
      READY:     if (grant) state_d = EXECUTING;
      EXECUTING: if (done) state_d = FREE;
      default:   state_d = FREE;
    endcase
  end

  always_comb begin
    is_free   = (state_q == FREE);
    is_ready  = (state_q == READY);
    op        = op_q;
    src1_data = data1_q;
    src2_data = data2_q;
  end

endmodule

// File: rtl/rs_station.sv
// Reservation station for one functional unit: allocates the lowest free slot on issue,
// snoops both CDB ports, and offers the lowest ready slot to the FU each cycle.
module rs_station
  import tomasulo_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = tomasulo_pkg::TAG_W,
  parameter int DATA_W      = tomasulo_pkg::DATA_W,
  parameter int TAG_BASE    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [1:0]        issue_op,
  input  logic [TAG_W-1:0]  issue_src1_tag,
  input  logic [DATA_W-1:0] issue_src1_data,
  input  logic [TAG_W-1:0]  issue_src2_tag,
  input  logic [DATA_W-1:0] issue_src2_data,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic [TAG_W-1:0]  AddBroadTag,
  input  logic [DATA_W-1:0] AddBroadData,
  input  logic [TAG_W-1:0]  MulBroadTag,
  input  logic [DATA_W-1:0] MulBroadData,
  output logic              disp_valid,
  input  logic              disp_ready,
  output logic [1:0]        disp_op,
  output logic [DATA_W-1:0] disp_a,
  output logic [DATA_W-1:0] disp_b,
  output logic [TAG_W-1:0]  disp_tag
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);

  logic [NUM_ENTRIES-1:0] free_vec, ready_vec, alloc_vec, grant_vec;
  op_t                    slot_op [NUM_ENTRIES];
  logic [DATA_W-1:0]      slot_a  [NUM_ENTRIES];
  logic [DATA_W-1:0]      slot_b  [NUM_ENTRIES];

  logic             alloc_found, disp_found, issue_fire, disp_fire;
  logic [IDX_W-1:0] alloc_idx, disp_idx;

  // Lowest-index priority encoder; the MSB of the result flags "any bit set".
  function automatic logic [IDX_W:0] lowest(input logic [NUM_ENTRIES-1:0] vec);
    lowest = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) lowest = {1'b1, IDX_W'(i)};
    end
  endfunction

  assign {alloc_found, alloc_idx} = lowest(free_vec);
  assign {disp_found, disp_idx}   = lowest(ready_vec);

  // Derived from registered slot state only: a slot freed this edge shows up next cycle.
  assign issue_ready = alloc_found;
  assign issue_fire  = issue_valid && alloc_found;
  assign disp_fire   = disp_found && disp_ready;
  assign issue_tag   = issue_fire ? TAG_W'(TAG_BASE) + TAG_W'(alloc_idx) : '0;

  always_comb begin
    alloc_vec = '0;
    grant_vec = '0;
    if (issue_fire) alloc_vec[alloc_idx] = 1'b1;
    if (disp_fire)  grant_vec[disp_idx]  = 1'b1;
  end

  always_comb begin
    disp_valid = disp_found;
    disp_op    = '0;
    disp_a     = '0;
    disp_b     = '0;
    disp_tag   = '0;
    if (disp_found) begin
      disp_op  = slot_op[disp_idx];
      disp_a   = slot_a[disp_idx];
      disp_b   = slot_b[disp_idx];
      disp_tag = TAG_W'(TAG_BASE) + TAG_W'(disp_idx);
    end
  end

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_slot
    rs_entry #(
      .TAG_W (TAG_W),
      .DATA_W(DATA_W)
    ) u_entry (
      .clk            (clk),
      .reset          (reset),
      .slot_tag       (TAG_W'(TAG_BASE + i)),
      .alloc          (alloc_vec[i]),
      .issue_op       (op_t'(issue_op)),
      .issue_src1_tag (issue_src1_tag),
      .issue_src1_data(issue_src1_data),
      .issue_src2_tag (issue_src2_tag),
      .issue_src2_data(issue_src2_data),
      .add_tag        (AddBroadTag),
      .add_data       (AddBroadData),
      .mul_tag        (MulBroadTag),
      .mul_data       (MulBroadData),
      .grant          (grant_vec[i]),
      .is_free        (free_vec[i]),
      .is_ready       (ready_vec[i]),
      .op             (slot_op[i]),
      .src1_data      (slot_a[i]),
      .src2_data      (slot_b[i])
    );
  end

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: directed vector table, async-reset sequences,
// and random traffic compared against a slot-list reference model.
module tb_rs_station;

  localparam int N  = 4;
  localparam int TB = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_ready, disp_valid, disp_ready;
  logic [1:0]  issue_op, disp_op;
  logic [3:0]  issue_src1_tag, issue_src2_tag, issue_tag, AddBroadTag, MulBroadTag, disp_tag;
  logic [31:0] issue_src1_data, issue_src2_data, AddBroadData, MulBroadData, disp_a, disp_b;

  always #5 clk = ~clk;

  rs_station #(.NUM_ENTRIES(N), .TAG_W(4), .DATA_W(32), .TAG_BASE(TB)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_src1_tag(issue_src1_tag), .issue_src1_data(issue_src1_data),
    .issue_src2_tag(issue_src2_tag), .issue_src2_data(issue_src2_data),
    .issue_tag(issue_tag),
    .AddBroadTag(AddBroadTag), .AddBroadData(AddBroadData),
    .MulBroadTag(MulBroadTag), .MulBroadData(MulBroadData),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_a(disp_a), .disp_b(disp_b), .disp_tag(disp_tag)
  );

  typedef struct {
    logic iv; logic [1:0] op;
    logic [3:0] t1; logic [31:0] d1; logic [3:0] t2; logic [31:0] d2;
    logic [3:0] at; logic [31:0] ad; logic [3:0] mt; logic [31:0] md;
    logic dr;
  } stim_t;

  typedef struct {
    logic ir; logic [3:0] itag; logic dv; logic [1:0] dop;
    logic [31:0] da; logic [31:0] db; logic [3:0] dtag;
  } exp_t;

  typedef struct { stim_t s; exp_t e; } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a list of occupied slots, each with pending tag or value per operand.
  bit          m_busy[N];
  bit          m_sent[N];
  logic [1:0]  m_op[N];
  logic [3:0]  m_w1[N], m_w2[N];
  logic [31:0] m_v1[N], m_v2[N];

  function automatic stim_t st(input int iv, op, t1, d1, t2, d2, at, ad, mt, md, dr);
    stim_t s;
    s.iv = iv[0]; s.op = op[1:0];
    s.t1 = t1[3:0]; s.d1 = d1; s.t2 = t2[3:0]; s.d2 = d2;
    s.at = at[3:0]; s.ad = ad; s.mt = mt[3:0]; s.md = md;
    s.dr = dr[0];
    return s;
  endfunction

  function automatic exp_t ex(input int ir, itag, dv, dop, da, db, dtag);
    exp_t e;
    e.ir = ir[0]; e.itag = itag[3:0]; e.dv = dv[0]; e.dop = dop[1:0];
    e.da = da; e.db = db; e.dtag = dtag[3:0];
    return e;
  endfunction

  task automatic add_vec(input stim_t s, input exp_t e);
    vec_t v;
    v.s = s;
    v.e = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input stim_t s);
    issue_valid = s.iv; issue_op = s.op;
    issue_src1_tag = s.t1; issue_src1_data = s.d1;
    issue_src2_tag = s.t2; issue_src2_data = s.d2;
    AddBroadTag = s.at; AddBroadData = s.ad;
    MulBroadTag = s.mt; MulBroadData = s.md;
    disp_ready = s.dr;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string where, input exp_t e);
    check({where, " issue_ready"}, 32'(issue_ready), 32'(e.ir));
    check({where, " issue_tag"},   32'(issue_tag),   32'(e.itag));
    check({where, " disp_valid"},  32'(disp_valid),  32'(e.dv));
    check({where, " disp_op"},     32'(disp_op),     32'(e.dop));
    check({where, " disp_a"},      disp_a,           e.da);
    check({where, " disp_b"},      disp_b,           e.db);
    check({where, " disp_tag"},    32'(disp_tag),    32'(e.dtag));
  endtask

  function automatic int first_free();
    for (int k = 0; k < N; k++) if (!m_busy[k]) return k;
    return -1;
  endfunction

  function automatic int first_ready();
    for (int k = 0; k < N; k++)
      if (m_busy[k] && !m_sent[k] && m_w1[k] == 0 && m_w2[k] == 0) return k;
    return -1;
  endfunction

  function automatic exp_t model_expect(input stim_t s);
    int   f = first_free();
    int   r = first_ready();
    exp_t e = ex(0, 0, 0, 0, 0, 0, 0);
    e.ir = (f >= 0);
    if (s.iv && f >= 0) e.itag = 4'(TB + f);
    if (r >= 0) begin
      e.dv = 1'b1; e.dop = m_op[r]; e.da = m_v1[r]; e.db = m_v2[r]; e.dtag = 4'(TB + r);
    end
    return e;
  endfunction

  // A pending operand resolves from the add bus first, otherwise from the mul bus.
  task automatic capture(inout logic [3:0] t, inout logic [31:0] v, input stim_t s);
    if (t != 0 && t == s.at) begin t = 0; v = s.ad; end
    else if (t != 0 && t == s.mt) begin t = 0; v = s.md; end
  endtask

  task automatic model_update(input stim_t s);
    int f = first_free();
    int r = first_ready();
    for (int k = 0; k < N; k++) begin
      if (m_busy[k]) begin
        if (m_sent[k]) begin
          if (s.at == 4'(TB + k) || s.mt == 4'(TB + k)) m_busy[k] = 1'b0;
        end else begin
          capture(m_w1[k], m_v1[k], s);
          capture(m_w2[k], m_v2[k], s);
        end
      end
    end
    if (r >= 0 && s.dr) m_sent[r] = 1'b1;
    if (f >= 0 && s.iv) begin
      m_busy[f] = 1'b1; m_sent[f] = 1'b0; m_op[f] = s.op;
      m_w1[f] = s.t1; m_v1[f] = s.d1;
      m_w2[f] = s.t2; m_v2[f] = s.d2;
      capture(m_w1[f], m_v1[f], s);
      capture(m_w2[f], m_v2[f], s);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_busy[k] = 1'b0; m_sent[k] = 1'b0;
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s.iv = 1'($urandom_range(0, 1));
    s.op = 2'($urandom_range(0, 3));
    s.t1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 10));
    s.d1 = $urandom;
    s.t2 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 10));
    s.d2 = $urandom;
    s.at = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
    s.ad = $urandom;
    s.mt = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 11));
    s.md = $urandom;
    s.dr = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  initial begin
    stim_t s;
    exp_t  e;

    //        iv op t1 d1    t2 d2    at ad    mt md    dr      ir itag dv op da    db    tag
    add_vec(st(1, 1, 0, 5,    0, 7,    0, 0,    0, 0,    0), ex(1, 1, 0, 0, 0,    0,    0));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    1), ex(1, 0, 1, 1, 5,    7,    1));
    add_vec(st(0, 0, 0, 0,    0, 0,    1, 'h55, 0, 0,    0), ex(1, 0, 0, 0, 0,    0,    0));
    add_vec(st(1, 2, 6, 0,    0, 3,    0, 0,    0, 0,    0), ex(1, 1, 0, 0, 0,    0,    0));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    1), ex(1, 0, 0, 0, 0,    0,    0));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    1), ex(1, 0, 0, 0, 0,    0,    0));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    6, 'h10, 0), ex(1, 0, 0, 0, 0,    0,    0));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    1), ex(1, 0, 1, 2, 'h10, 3,    1));
    add_vec(st(1, 3, 6, 0,    7, 0,    6, 'hA,  7, 'hB,  0), ex(1, 2, 0, 0, 0,    0,    0));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    0), ex(1, 0, 1, 3, 'hA,  'hB,  2));
    add_vec(st(0, 0, 0, 0,    0, 0,    1, 0,    2, 0,    0), ex(1, 0, 1, 3, 'hA,  'hB,  2));
    add_vec(st(1, 0, 0, 1,    0, 2,    0, 0,    0, 0,    0), ex(1, 1, 1, 3, 'hA,  'hB,  2));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    1), ex(1, 0, 1, 0, 1,    2,    1));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    1), ex(1, 0, 1, 3, 'hA,  'hB,  2));
    add_vec(st(0, 0, 0, 0,    0, 0,    1, 0,    2, 0,    0), ex(1, 0, 0, 0, 0,    0,    0));
    add_vec(st(1, 1, 9, 0,    9, 0,    0, 0,    0, 0,    0), ex(1, 1, 0, 0, 0,    0,    0));
    add_vec(st(1, 1, 9, 0,    9, 0,    0, 0,    0, 0,    0), ex(1, 2, 0, 0, 0,    0,    0));
    add_vec(st(1, 1, 9, 0,    9, 0,    0, 0,    0, 0,    0), ex(1, 3, 0, 0, 0,    0,    0));
    add_vec(st(1, 1, 9, 0,    9, 0,    0, 0,    0, 0,    0), ex(1, 4, 0, 0, 0,    0,    0));
    add_vec(st(1, 1, 9, 0,    9, 0,    0, 0,    0, 0,    0), ex(0, 0, 0, 0, 0,    0,    0));
    add_vec(st(1, 1, 9, 0,    9, 0,    9, 'h20, 0, 0,    0), ex(0, 0, 0, 0, 0,    0,    0));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    0), ex(0, 0, 1, 1, 'h20, 'h20, 1));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    0), ex(0, 0, 1, 1, 'h20, 'h20, 1));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    1), ex(0, 0, 1, 1, 'h20, 'h20, 1));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    1), ex(0, 0, 1, 1, 'h20, 'h20, 2));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    1), ex(0, 0, 1, 1, 'h20, 'h20, 3));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    3, 0,    0), ex(0, 0, 1, 1, 'h20, 'h20, 4));
    add_vec(st(1, 2, 0, 'h30, 0, 'h40, 0, 0,    0, 0,    0), ex(1, 3, 1, 1, 'h20, 'h20, 4));
    add_vec(st(0, 0, 0, 0,    0, 0,    0, 0,    0, 0,    1), ex(0, 0, 1, 2, 'h30, 'h40, 3));
    add_vec(st(0, 0, 0, 0,    0, 0,    12, 'h77, 0, 0,   0), ex(0, 0, 1, 1, 'h20, 'h20, 4));

    reset = 1'b1;
    drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #12;
    check_outputs("reset", ex(1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].s);
      #1;
      check_outputs($sformatf("vec%0d", i), tbl[i].e);
    end

    // Async reset with three slots executing and one ready, then late results for old tags.
    @(negedge clk);
    drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    check_outputs("pre_reset", ex(0, 0, 1, 1, 'h20, 'h20, 4));
    #1 reset = 1'b1;
    #1 check_outputs("reset_async", ex(1, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(st(0, 0, 0, 0, 0, 0, 1 + c, 'h99, 2 + c, 'h98, 1));
      #1;
      check_outputs($sformatf("reset_hold%0d", c), ex(1, 0, 0, 0, 0, 0, 0));
    end
    @(negedge clk);
    reset = 1'b0;
    drive(st(0, 0, 0, 0, 0, 0, 1, 'h99, 3, 'h98, 1));
    #1 check_outputs("late_result", ex(1, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(st(1, 1, 0, 'h11, 0, 'h22, 0, 0, 0, 0, 0));
    #1 check_outputs("post_reset_issue", ex(1, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1 check_outputs("post_reset_disp", ex(1, 0, 1, 1, 'h11, 'h22, 1));

    // Random traffic against the reference model.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      s = rand_stim();
      drive(s);
      #1;
      e = model_expect(s);
      check_outputs($sformatf("rand%0d", cyc), e);
      model_update(s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
